// File: rtl/pipe_pkg.sv
// Shared types for the pipeline front end: redirect kinds (ranked by encoding),
// PC generator FSM states and default vector addresses.
package pipe_pkg;

    // Numeric order is the arbitration rank: EXC > BR > JMP > NONE.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        JMP  = 2'd1,
        BR   = 2'd2,
        EXC  = 2'd3
    } redirect_kind_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VEC   = 32'h0000_0100;

    function automatic redirect_kind_t rank_of(input logic exc, input logic br, input logic jmp);
        if (exc) return EXC;
        if (br)  return BR;
        if (jmp) return JMP;
        return NONE;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry redirect holding register; a capture only replaces the held
// entry when its kind outranks it, and clear wins over capture.
module pc_redirect_buf
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cap,
    input  redirect_kind_t       cap_kind,
    input  logic [XLEN-1:0]      cap_target,
    input  logic                 clr,
    output logic                 valid,
    output redirect_kind_t       kind,
    output logic [XLEN-1:0]      target
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid  <= 1'b0;
            kind   <= NONE;
            target <= '0;
        end else if (cap && (cap_kind > kind)) begin
            valid  <= 1'b1;
            kind   <= cap_kind;
            target <= cap_target;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with stall-time redirect buffering.
// Optional target alignment checking is enabled by defining PC_ALIGN_CHECK_EN.
module pc_gen
    import pipe_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              INSTR_BYTES = 4,
    parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(DEFAULT_RESET_VEC),
    parameter logic [XLEN-1:0] EXC_VEC     = XLEN'(DEFAULT_EXC_VEC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            exc_req,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jmp_taken,
    input  logic [XLEN-1:0] jmp_target,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            redirect_pend
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic            misalign,
    output logic [XLEN-1:0] bad_addr
`endif
);

    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    pc_state_t       state;
    redirect_kind_t  req_kind;
    redirect_kind_t  buf_kind;
    redirect_kind_t  sel_kind;
    logic [XLEN-1:0] req_target;
    logic [XLEN-1:0] buf_target;
    logic [XLEN-1:0] sel_target;
    logic [XLEN-1:0] next_pc;
    logic            buf_valid;
    logic            buf_cap;
    logic            buf_clr;
`ifdef PC_ALIGN_CHECK_EN
    logic            sel_misalign;
`endif

    always_comb begin
        req_kind = rank_of(exc_req, br_taken, jmp_taken);
        unique case (req_kind)
            EXC:     req_target = EXC_VEC;
            BR:      req_target = br_target;
            JMP:     req_target = jmp_target;
            default: req_target = pc + STEP;
        endcase
    end

    // A buffered redirect is applied on release; only a fresh exception beats it.
    always_comb begin
        sel_kind   = req_kind;
        sel_target = req_target;
        if (state == PEND && buf_valid) begin
            if (exc_req) begin
                sel_kind   = EXC;
                sel_target = EXC_VEC;
            end else begin
                sel_kind   = buf_kind;
                sel_target = buf_target;
            end
        end
    end

    always_comb begin
        next_pc = sel_target;
`ifdef PC_ALIGN_CHECK_EN
        sel_misalign = 1'b0;
        if ((sel_kind == BR || sel_kind == JMP) && ((sel_target & ALIGN_MASK) != '0)) begin
            next_pc      = EXC_VEC;
            sel_misalign = 1'b1;
        end
`else
        if (sel_kind == BR || sel_kind == JMP)
            next_pc = sel_target & ~ALIGN_MASK;
`endif
    end

    assign buf_cap = (state != BOOT) && !en && (req_kind != NONE);
    assign buf_clr = (state == PEND) && en;

    pc_redirect_buf #(.XLEN(XLEN)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .cap        (buf_cap),
        .cap_kind   (req_kind),
        .cap_target (req_target),
        .clr        (buf_clr),
        .valid      (buf_valid),
        .kind       (buf_kind),
        .target     (buf_target)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            pc            <= RESET_VEC - STEP;
            pc_valid      <= 1'b0;
            redirect_pend <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign      <= 1'b0;
            bad_addr      <= '0;
`endif
        end else begin
`ifdef PC_ALIGN_CHECK_EN
            misalign <= 1'b0;
`endif
            unique case (state)
                BOOT: begin
                    if (en) begin
                        pc       <= RESET_VEC;
                        pc_valid <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN, PEND: begin
                    if (en) begin
                        pc            <= next_pc;
                        state         <= RUN;
                        redirect_pend <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
                        if (sel_misalign) begin
                            misalign <= 1'b1;
                            bad_addr <= sel_target;
                        end
`endif
                    end else if (req_kind != NONE) begin
                        state         <= PEND;
                        redirect_pend <= 1'b1;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule
